// File: rtl/axis_fifo_pkg.sv
// Shared defaults and fill-state encoding for the 64-bit AXI4-Stream packet FIFO.
package axis_fifo_pkg;

    localparam int DATA_WIDTH_DEFAULT = 64;
    localparam int DEPTH_DEFAULT      = 64;

    localparam logic [1:0] ST_EMPTY  = 2'd0;
    localparam logic [1:0] ST_ACTIVE = 2'd1;
    localparam logic [1:0] ST_FULL   = 2'd2;

    function automatic logic [1:0] fill_state(input int unsigned cnt, input int unsigned depth);
        if (cnt == 0)
            return ST_EMPTY;
        else if (cnt == depth)
            return ST_FULL;
        else
            return ST_ACTIVE;
    endfunction

endpackage

// File: rtl/axis_fifo_ram.sv
// Simple dual-port storage, synchronous write and synchronous read; entry MSB carries TLAST.
module axis_fifo_ram
    import axis_fifo_pkg::*;
#(
    parameter  int WIDTH = DATA_WIDTH_DEFAULT + 1,
    parameter  int DEPTH = DEPTH_DEFAULT,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic             clk_i,
    input  logic             we_i,
    input  logic [AW-1:0]    waddr_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic [AW-1:0]    raddr_i,
    output logic [WIDTH-1:0] rdata_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] rdata_q;

    // Write-first on an address collision so the prefetched head word is never stale.
    always_ff @(posedge clk_i) begin
        if (we_i)
            mem_q[waddr_i] <= wdata_i;
        rdata_q <= (we_i && (waddr_i == raddr_i)) ? wdata_i : mem_q[raddr_i];
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/axis_pkt_fifo_64.sv
// AXI4-Stream FIFO with registered output and fill level between width converter and DMA.
// Optional store-and-forward mode with oversize fallback: define AXIS_PKT_FIFO_STORE_FWD_EN.
module axis_pkt_fifo_64
    import axis_fifo_pkg::*;
#(
    parameter  int DATA_WIDTH = DATA_WIDTH_DEFAULT,
    parameter  int DEPTH      = DEPTH_DEFAULT,
    localparam int ADDR_WIDTH = $clog2(DEPTH)
) (
    input  logic                  aclk,
    input  logic                  areset,
    input  logic [DATA_WIDTH-1:0] S_AXIS_TDATA,
    input  logic                  S_AXIS_TVALID,
    input  logic                  S_AXIS_TLAST,
    output logic                  S_AXIS_TREADY,
    output logic [DATA_WIDTH-1:0] M_AXIS_TDATA,
    output logic                  M_AXIS_TVALID,
    output logic                  M_AXIS_TLAST,
    input  logic                  M_AXIS_TREADY,
    output logic [ADDR_WIDTH:0]   fill_level,
    output logic                  err_oversize
);

    localparam logic [ADDR_WIDTH:0]   CNT_FULL = (ADDR_WIDTH+1)'(DEPTH);
    localparam logic [ADDR_WIDTH:0]   CNT_ONE  = (ADDR_WIDTH+1)'(1);
    localparam logic [ADDR_WIDTH-1:0] PTR_ONE  = ADDR_WIDTH'(1);

    logic [ADDR_WIDTH:0]   count_q, count_d, ram_cnt;
    logic [ADDR_WIDTH-1:0] wr_ptr_q, rd_ptr_q, rd_ptr_d;
    logic [1:0]            state_q, state_d;
    logic                  out_valid_q, out_last_q;
    logic [DATA_WIDTH-1:0] out_data_q;
    logic                  accept, emit, allow, load, from_ram, ram_we;
    logic [DATA_WIDTH:0]   ram_rdata;
    logic [DATA_WIDTH-1:0] load_data;
    logic                  load_last;

    assign accept   = S_AXIS_TVALID && S_AXIS_TREADY;
    assign emit     = out_valid_q && M_AXIS_TREADY;
    assign ram_cnt  = count_q - {{ADDR_WIDTH{1'b0}}, out_valid_q};

    // Refill the output slot from the RAM head, or straight from the input when the RAM is empty.
    assign load      = (!out_valid_q || emit) && allow && ((ram_cnt != '0) || accept);
    assign from_ram  = load && (ram_cnt != '0);
    assign ram_we    = accept && !(load && !from_ram);
    assign load_data = from_ram ? ram_rdata[DATA_WIDTH-1:0] : S_AXIS_TDATA;
    assign load_last = from_ram ? ram_rdata[DATA_WIDTH] : S_AXIS_TLAST;
    assign rd_ptr_d  = from_ram ? rd_ptr_q + PTR_ONE : rd_ptr_q;

    always_comb begin
        count_d = count_q;
        if (accept && !emit)
            count_d = count_q + CNT_ONE;
        else if (!accept && emit)
            count_d = count_q - CNT_ONE;
        state_d = fill_state(32'(count_d), DEPTH);
    end

    axis_fifo_ram #(
        .WIDTH (DATA_WIDTH + 1),
        .DEPTH (DEPTH)
    ) u_ram (
        .clk_i   (aclk),
        .we_i    (ram_we),
        .waddr_i (wr_ptr_q),
        .wdata_i ({S_AXIS_TLAST, S_AXIS_TDATA}),
        .raddr_i (rd_ptr_d),
        .rdata_o (ram_rdata)
    );

    always_ff @(posedge aclk) begin
        if (areset) begin
            count_q     <= '0;
            state_q     <= ST_EMPTY;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            out_data_q  <= '0;
        end else begin
            count_q  <= count_d;
            state_q  <= state_d;
            rd_ptr_q <= rd_ptr_d;
            if (ram_we)
                wr_ptr_q <= wr_ptr_q + PTR_ONE;
            if (load) begin
                out_valid_q <= 1'b1;
                out_data_q  <= load_data;
                out_last_q  <= load_last;
            end else if (emit) begin
                out_valid_q <= 1'b0;
            end
        end
    end

`ifdef AXIS_PKT_FIFO_STORE_FWD_EN
    logic [ADDR_WIDTH:0] pkt_cnt_q, pkt_cnt_d, pkt_avail;
    logic                mid_load_q, ovs_q, err_q;
    logic                acc_last, emit_last;

    assign acc_last  = accept && S_AXIS_TLAST;
    assign emit_last = emit && out_last_q;
    // Complete packets with at least one word not yet moved into the output slot.
    assign pkt_avail = pkt_cnt_q - {{ADDR_WIDTH{1'b0}}, out_valid_q && out_last_q};
    assign allow     = mid_load_q || ovs_q || (pkt_avail != '0) || acc_last;

    always_comb begin
        pkt_cnt_d = pkt_cnt_q;
        if (acc_last && !emit_last)
            pkt_cnt_d = pkt_cnt_q + CNT_ONE;
        else if (!acc_last && emit_last)
            pkt_cnt_d = pkt_cnt_q - CNT_ONE;
    end

    always_ff @(posedge aclk) begin
        if (areset) begin
            pkt_cnt_q  <= '0;
            mid_load_q <= 1'b0;
            ovs_q      <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            pkt_cnt_q <= pkt_cnt_d;
            if (load)
                mid_load_q <= !load_last;
            if ((count_q == CNT_FULL) && (pkt_cnt_q == '0)) begin
                ovs_q <= 1'b1;
                err_q <= 1'b1;
            end else if (emit_last) begin
                ovs_q <= 1'b0;
            end
        end
    end

    assign err_oversize = err_q;
`else
    assign allow        = 1'b1;
    assign err_oversize = 1'b0;
`endif

    assign S_AXIS_TREADY = !areset && (state_q != ST_FULL);
    assign M_AXIS_TVALID = out_valid_q;
    assign M_AXIS_TDATA  = out_data_q;
    assign M_AXIS_TLAST  = out_last_q;
    assign fill_level    = count_q;

endmodule

// File: tb/tb_axis_pkt_fifo_64.sv
// Randomized self-checking bench for axis_pkt_fifo_64 against a queue-based stream model.
// Follows AXIS_PKT_FIFO_STORE_FWD_EN the same way the design does.
module tb_axis_pkt_fifo_64;

    localparam int DEPTH = 64;
`ifdef AXIS_PKT_FIFO_STORE_FWD_EN
    localparam bit SF = 1'b1;
`else
    localparam bit SF = 1'b0;
`endif

    typedef struct packed {
        logic        last;
        logic [63:0] data;
    } beat_t;

    logic        clk = 1'b0;
    logic        areset;
    logic [63:0] s_data;
    logic        s_valid, s_last, s_ready;
    logic [63:0] m_data;
    logic        m_valid, m_last, m_ready;
    logic [6:0]  fill_level;
    logic        err_oversize;

    axis_pkt_fifo_64 dut (
        .aclk          (clk),
        .areset        (areset),
        .S_AXIS_TDATA  (s_data),
        .S_AXIS_TVALID (s_valid),
        .S_AXIS_TLAST  (s_last),
        .S_AXIS_TREADY (s_ready),
        .M_AXIS_TDATA  (m_data),
        .M_AXIS_TVALID (m_valid),
        .M_AXIS_TLAST  (m_last),
        .M_AXIS_TREADY (m_ready),
        .fill_level    (fill_level),
        .err_oversize  (err_oversize)
    );

    always #5 clk = ~clk;

    int vectors     = 0;
    int miscompares = 0;

    task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h, expected %h at %0t", tag, act, exp, $time);
        end
    endtask

    // Reference model: every word accepted and not yet emitted, oldest first.
    beat_t mq[$];
    beat_t src[$];
    int    tl_cnt    = 0;
    bit    err_m     = 0;
    bit    ovs_m     = 0;
    bit    partial_m = 0;
    int    max_fill  = 0;
    int    n_emit    = 0;
    bit    chk_en    = 0;

    always @(posedge clk) begin
        bit    pre_full;
        int    pre_tl;
        beat_t b;
        if (areset) begin
            mq.delete();
            tl_cnt    = 0;
            err_m     = 0;
            ovs_m     = 0;
            partial_m = 0;
        end else begin
            pre_full = (mq.size() == DEPTH);
            pre_tl   = tl_cnt;
            if (m_valid && m_ready) begin
                if (mq.size() == 0) begin
                    check_eq("emit_from_empty", 64'(m_valid), 64'd0);
                end else begin
                    b = mq.pop_front();
                    n_emit++;
                    if (b.last) begin
                        tl_cnt--;
                        partial_m = 0;
                        ovs_m     = 0;
                    end else begin
                        partial_m = 1;
                    end
                end
            end
            if (s_valid && !pre_full) begin
                mq.push_back('{last: s_last, data: s_data});
                if (s_last) tl_cnt++;
            end
            if (SF && pre_full && pre_tl == 0) begin
                err_m = 1;
                ovs_m = 1;
            end
            if (mq.size() > max_fill) max_fill = mq.size();
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check_eq("fill_level", 64'(fill_level), 64'(mq.size()));
            check_eq("s_tready", 64'(s_ready), 64'(!areset && mq.size() != DEPTH));
            check_eq("err_oversize", 64'(err_oversize), 64'(err_m));
            if (mq.size() == 0)
                check_eq("m_tvalid", 64'(m_valid), 64'd0);
            else if (!SF || tl_cnt > 0 || partial_m)
                check_eq("m_tvalid", 64'(m_valid), 64'd1);
            else if (!ovs_m)
                check_eq("m_tvalid", 64'(m_valid), 64'd0);
            if (m_valid && mq.size() > 0) begin
                check_eq("m_tdata", m_data, mq[0].data);
                check_eq("m_tlast", 64'(m_last), 64'(mq[0].last));
            end
        end
    end

    // Sink: 0 always ready, 1 never, 2 random, 3 stall once on stall_word, 4 single pulse.
    int          rdy_mode   = 0;
    logic [63:0] stall_word = '0;
    bit          stall_done = 0;
    bit          oneshot    = 0;

    initial begin
        m_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            case (rdy_mode)
                0: m_ready = 1'b1;
                1: m_ready = 1'b0;
                2: m_ready = ($urandom_range(0, 3) != 0);
                3: begin
                    if (!stall_done && m_valid && m_data == stall_word) begin
                        m_ready    = 1'b0;
                        stall_done = 1;
                    end else begin
                        m_ready = 1'b1;
                    end
                end
                default: begin
                    m_ready = oneshot;
                    oneshot = 0;
                end
            endcase
        end
    end

    bit src_gaps = 0;

    task automatic tick(input int n);
        bit acc;
        repeat (n) begin
            if (src.size() > 0 && (!src_gaps || $urandom_range(0, 3) != 0)) begin
                s_valid = 1'b1;
                s_data  = src[0].data;
                s_last  = src[0].last;
            end else begin
                s_valid = 1'b0;
                s_data  = '0;
                s_last  = 1'b0;
            end
            @(negedge clk);
            acc = s_valid && s_ready;
            @(posedge clk);
            #1;
            if (acc) void'(src.pop_front());
        end
    endtask

    task automatic do_reset();
        areset = 1'b1;
        src.delete();
        tick(2);
        areset = 1'b0;
        max_fill = 0;
        n_emit   = 0;
    endtask

    task automatic run_until_empty(input int budget);
        int b = budget;
        while ((src.size() > 0 || mq.size() > 0) && b > 0) begin
            tick(1);
            b--;
        end
        check_eq("drain_done", 64'(src.size() + mq.size()), 64'd0);
    endtask

    task automatic load_pattern(input int n, input int last_idx);
        logic [63:0] base = 64'h0706050403020100;
        logic [63:0] step = 64'h0808080808080808;
        for (int i = 0; i < n; i++)
            src.push_back('{last: (i == last_idx), data: base + step * 64'(i)});
    endtask

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation time limit reached, got no finish, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        areset  = 1'b1;
        s_valid = 1'b0;
        s_data  = '0;
        s_last  = 1'b0;

        // Reset then idle
        @(posedge clk);
        #1;
        chk_en = 1;
        tick(1);
        check_eq("rst_tready", 64'(s_ready), 64'd0);
        check_eq("rst_tvalid", 64'(m_valid), 64'd0);
        check_eq("rst_tdata", m_data, 64'd0);
        check_eq("rst_tlast", 64'(m_last), 64'd0);
        check_eq("rst_fill", 64'(fill_level), 64'd0);
        areset = 1'b0;
        tick(1);
        check_eq("post_rst_tready", 64'(s_ready), 64'd1);
        check_eq("post_rst_fill", 64'(fill_level), 64'd0);

        // Streaming, 12 words
        do_reset();
        rdy_mode = 0;
        load_pattern(12, 11);
        run_until_empty(100);
        check_eq("stream_emits", 64'(n_emit), 64'd12);
        check_eq("stream_max_fill", 64'(max_fill), SF ? 64'd12 : 64'd1);

        // Back-pressure on word 5
        do_reset();
        stall_word = 64'h0706050403020100 + 64'h0808080808080808 * 64'd5;
        stall_done = 0;
        rdy_mode   = 3;
        load_pattern(12, 11);
        run_until_empty(100);
        check_eq("bp_stalled", 64'(stall_done), 64'd1);
        check_eq("bp_emits", 64'(n_emit), 64'd12);
        check_eq("bp_max_fill", 64'(max_fill), SF ? 64'd12 : 64'd2);

        // Full
        do_reset();
        rdy_mode = 1;
        load_pattern(70, 63);
        tick(80);
        check_eq("full_fill", 64'(fill_level), 64'd64);
        check_eq("full_tready", 64'(s_ready), 64'd0);
        check_eq("full_leftover", 64'(src.size()), 64'd6);
        src.delete();
        oneshot  = 1;
        rdy_mode = 4;
        tick(4);
        check_eq("full_one_emit_fill", 64'(fill_level), 64'd63);
        check_eq("full_one_emit_tready", 64'(s_ready), 64'd1);
        rdy_mode = 0;
        run_until_empty(200);
        check_eq("full_emits", 64'(n_emit), 64'd64);

        // Held packet: 8 words without TLAST, then the closing word
        do_reset();
        rdy_mode = 0;
        load_pattern(8, -1);
        tick(14);
        check_eq("sf_hold_valid", 64'(m_valid), 64'd0);
        check_eq("sf_hold_fill", 64'(fill_level), SF ? 64'd8 : 64'd0);
        src.push_back('{last: 1'b1, data: 64'hDEAD_BEEF_0000_0009});
        run_until_empty(100);
        check_eq("sf_emits", 64'(n_emit), 64'd9);

        // Oversize: 80 words, no TLAST
        do_reset();
        rdy_mode = 0;
        load_pattern(80, -1);
        run_until_empty(400);
        check_eq("ovs_emits", 64'(n_emit), 64'd80);
        check_eq("ovs_flag", 64'(err_oversize), 64'(SF));
        tick(5);
        check_eq("ovs_flag_sticky", 64'(err_oversize), 64'(SF));
        do_reset();
        check_eq("ovs_flag_cleared", 64'(err_oversize), 64'd0);

        // Random traffic, reset while words are in flight
        rdy_mode = 2;
        src_gaps = 1;
        for (int i = 0; i < 300; i++)
            src.push_back('{last: ($urandom_range(0, 7) == 0), data: {$urandom, $urandom}});
        tick(150);
        do_reset();
        check_eq("midrst_fill", 64'(fill_level), 64'd0);
        check_eq("midrst_tvalid", 64'(m_valid), 64'd0);

        // Random traffic, fully drained
        for (int i = 0; i < 400; i++)
            src.push_back('{last: ($urandom_range(0, 7) == 0 || i == 399), data: {$urandom, $urandom}});
        run_until_empty(4000);
        check_eq("rand_emits", 64'(n_emit), 64'd400);
        src_gaps = 0;

        tick(2);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
